alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 126 ++++++++++++
 tb/tb_alu_issue_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-entry skid buffer issuing resolved operands to the ALU
// Define ALU_ISSUE_FWD_EN to enable EX/MEM operand forwarding at accept time.
module alu_issue_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            inValid,
   output logic            inReady,
   input  logic [3:0]      inCtrl,
   input  logic [4:0]      inRs1,
   input  logic [4:0]      inRs2,
   input  logic [XLEN-1:0] inRs1Data,
   input  logic [XLEN-1:0] inRs2Data,
   input  logic [XLEN-1:0] inImm,
   input  logic            inUseImm,
   input  logic [4:0]      inRd,
   input  logic            fwdExValid,
   input  logic [4:0]      fwdExRd,
   input  logic [XLEN-1:0] fwdExData,
   input  logic            fwdMemValid,
   input  logic [4:0]      fwdMemRd,
   input  logic [XLEN-1:0] fwdMemData,
   output logic            outValid,
   input  logic            outReady,
   output logic [3:0]      ctrlSignal,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [4:0]      outRd
);

   localparam int EW = 4 + 2 * XLEN + 5;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t          state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic [EW-1:0]   main_q, main_d;
   logic [EW-1:0]   skid_q, skid_d;
   logic [EW-1:0]   new_entry;
   logic [XLEN-1:0] op1_res, op2_res;
   logic            accept, consume;

`ifdef ALU_ISSUE_FWD_EN
   // EX is the younger producer, so it wins over MEM; x0 is never forwarded.
   function automatic logic [XLEN-1:0] fwd(input logic [4:0] r, input logic [XLEN-1:0] d);
      if (r != 5'd0 && fwdExValid && fwdExRd == r)
         return fwdExData;
      else if (r != 5'd0 && fwdMemValid && fwdMemRd == r)
         return fwdMemData;
      else
         return d;
   endfunction

   assign op1_res = fwd(inRs1, inRs1Data);
   assign op2_res = inUseImm ? inImm : fwd(inRs2, inRs2Data);
`else
   logic unused_fwd;
   assign unused_fwd = &{1'b0, fwdExValid, fwdExRd, fwdExData, fwdMemValid, fwdMemRd,
                         fwdMemData, inRs1, inRs2};
   assign op1_res = inRs1Data;
   assign op2_res = inUseImm ? inImm : inRs2Data;
`endif

   assign new_entry = {inCtrl, op1_res, op2_res, inRd};
   assign accept    = inValid && in_ready_q;
   assign consume   = (state_q != EMPTY) && outReady;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = new_entry;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && consume) begin
               main_d = new_entry;
            end else if (accept) begin
               skid_d  = new_entry;
               state_d = TWO;
            end else if (consume) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (consume) begin
               main_d  = skid_q;
               skid_d  = '0;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
         skid_d  = '0;
      end
      // Ready is a pure function of the next state, so it never sees outReady combinationally.
      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

   assign inReady  = in_ready_q;
   assign outValid = (state_q != EMPTY);
   assign {ctrlSignal, op1, op2, outRd} = main_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [3:0]  inCtrl = '0;
   logic [4:0]  inRs1 = '0, inRs2 = '0, inRd = '0;
   logic [31:0] inRs1Data = '0, inRs2Data = '0, inImm = '0;
   logic        inUseImm = 1'b0;
   logic        fwdExValid = 1'b0, fwdMemValid = 1'b0;
   logic [4:0]  fwdExRd = '0, fwdMemRd = '0;
   logic [31:0] fwdExData = '0, fwdMemData = '0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [3:0]  ctrlSignal;
   logic [31:0] op1, op2;
   logic [4:0]  outRd;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
   } ent_t;

   ent_t sb[$];

   alu_issue_stage #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .inValid(inValid), .inReady(inReady), .inCtrl(inCtrl),
      .inRs1(inRs1), .inRs2(inRs2), .inRs1Data(inRs1Data), .inRs2Data(inRs2Data),
      .inImm(inImm), .inUseImm(inUseImm), .inRd(inRd),
      .fwdExValid(fwdExValid), .fwdExRd(fwdExRd), .fwdExData(fwdExData),
      .fwdMemValid(fwdMemValid), .fwdMemRd(fwdMemRd), .fwdMemData(fwdMemData),
      .outValid(outValid), .outReady(outReady), .ctrlSignal(ctrlSignal),
      .op1(op1), .op2(op2), .outRd(outRd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fwd_m(input logic [4:0] r, input logic [31:0] d);
`ifdef ALU_ISSUE_FWD_EN
      if (r != 0 && fwdExValid && fwdExRd == r) return fwdExData;
      if (r != 0 && fwdMemValid && fwdMemRd == r) return fwdMemData;
`endif
      return d;
   endfunction

   // Sampled mid-cycle: what the next rising edge will consume and accept.
   always @(negedge clk) begin
      if (reset || flush) begin
         sb.delete();
      end else begin
         if (outValid && outReady) begin
            if (sb.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               ent_t e;
               e = sb.pop_front();
               check("sb_ctrl", ctrlSignal, e.ctrl);
               check("sb_op1", op1, e.op1);
               check("sb_op2", op2, e.op2);
               check("sb_rd", outRd, e.rd);
            end
         end
         if (inValid && inReady) begin
            ent_t n;
            n.ctrl = inCtrl;
            n.op1  = fwd_m(inRs1, inRs1Data);
            n.op2  = inUseImm ? inImm : fwd_m(inRs2, inRs2Data);
            n.rd   = inRd;
            sb.push_back(n);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd);
      inValid = 1'b1; inCtrl = c; inRs1 = r1; inRs1Data = d1;
      inRs2 = r2; inRs2Data = d2; inRd = rd; inUseImm = 1'b0; inImm = '0;
   endtask

   task automatic set_fwd(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                          input logic mv, input logic [4:0] mr, input logic [31:0] md);
      fwdExValid = ev; fwdExRd = er; fwdExData = ed;
      fwdMemValid = mv; fwdMemRd = mr; fwdMemData = md;
   endtask

   task automatic fwd_case(input string tag, input logic [4:0] r1, input logic [31:0] d1,
                           input logic [4:0] r2, input logic [31:0] d2,
                           input logic [31:0] e1, input logic [31:0] e2);
      drive(4'h1, r1, d1, r2, d2, 5'd9);
      outReady = 1'b1;
      tick();
      inValid = 1'b0;
      check({tag, "_op1"}, op1, e1);
      check({tag, "_op2"}, op2, e2);
      tick();
   endtask

   initial begin
      bit acc;
      #2 reset = 1'b1;
      #1;
      check("rst_out_valid", outValid, 0);
      check("rst_in_ready", inReady, 1);
      check("rst_ctrl", ctrlSignal, 0);
      check("rst_op1", op1, 0);
      check("rst_op2", op2, 0);
      check("rst_rd", outRd, 0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // Single entry, one-cycle latency
      outReady = 1'b1;
      drive(4'b0010, 5'd1, 32'd5, 5'd2, 32'd7, 5'd4);
      tick();
      inValid = 1'b0;
      check("lat_valid", outValid, 1);
      check("lat_ctrl", ctrlSignal, 4'b0010);
      check("lat_op1", op1, 5);
      check("lat_op2", op2, 7);
      tick();
      check("lat_drained", outValid, 0);

      // Back-pressure: two fill the buffer, the third waits
      outReady = 1'b0;
      drive(4'h3, 5'd1, 32'hA1, 5'd2, 32'hA2, 5'd10);
      tick();
      drive(4'h4, 5'd1, 32'hB1, 5'd2, 32'hB2, 5'd11);
      tick();
      check("full_in_ready", inReady, 0);
      drive(4'h5, 5'd1, 32'hC1, 5'd2, 32'hC2, 5'd12);
      tick();
      check("hold_in_ready", inReady, 0);
      check("hold_op1", op1, 32'hA1);
      tick();
      check("hold_op1_2", op1, 32'hA1);
      check("hold_ctrl", ctrlSignal, 4'h3);
      outReady = 1'b1;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (inReady) begin acc = 1; break; end
      end
      check("accept_timeout", acc, 1);
      @(posedge clk); #1;
      inValid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("bp_drained", sb.size(), 0);

      // Forwarding and immediate selection
      set_fwd(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
`ifdef ALU_ISSUE_FWD_EN
      fwd_case("fwd_ex", 5'd3, 32'h11, 5'd6, 32'h22, 32'hAA, 32'h22);
      set_fwd(0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
      fwd_case("fwd_mem", 5'd3, 32'h11, 5'd6, 32'h22, 32'hBB, 32'h22);
      set_fwd(0, 5'd0, 32'h0, 1, 5'd6, 32'hCC);
      fwd_case("fwd_mem_rs2", 5'd3, 32'h11, 5'd6, 32'h22, 32'h11, 32'hCC);
`else
      fwd_case("nofwd_ex", 5'd3, 32'h11, 5'd6, 32'h22, 32'h11, 32'h22);
      set_fwd(1, 5'd3, 32'h55, 0, 5'd0, 32'h0);
      fwd_case("nofwd_55", 5'd3, 32'h11, 5'd6, 32'h22, 32'h11, 32'h22);
`endif
      set_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
      fwd_case("fwd_x0", 5'd0, 32'h11, 5'd0, 32'h22, 32'h11, 32'h22);
      set_fwd(1, 5'd5, 32'hAA, 0, 5'd0, 32'h0);
      drive(4'h6, 5'd1, 32'h1, 5'd5, 32'h2, 5'd7);
      inUseImm = 1'b1; inImm = 32'hFFFFFFF0;
      tick();
      inValid = 1'b0; inUseImm = 1'b0;
      check("imm_op2", op2, 32'hFFFFFFF0);
      tick();
      set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

      // Flush in TWO with a simultaneous input
      outReady = 1'b0;
      drive(4'h7, 5'd1, 32'h71, 5'd2, 32'h72, 5'd1);
      tick();
      drive(4'h8, 5'd1, 32'h81, 5'd2, 32'h82, 5'd2);
      tick();
      check("flush_pre_full", inReady, 0);
      drive(4'h9, 5'd1, 32'h91, 5'd2, 32'h92, 5'd3);
      flush = 1'b1;
      tick();
      flush = 1'b0; inValid = 1'b0;
      check("flush_out_valid", outValid, 0);
      check("flush_in_ready", inReady, 1);
      outReady = 1'b1;
      tick(); tick();
      check("flush_dropped", outValid, 0);
      drive(4'hA, 5'd1, 32'hD1, 5'd2, 32'hD2, 5'd4);
      tick();
      inValid = 1'b0;
      check("post_flush_op1", op1, 32'hD1);
      tick();

      // Reset mid-transfer
      outReady = 1'b0;
      drive(4'hB, 5'd1, 32'hE1, 5'd2, 32'hE2, 5'd5);
      tick();
      drive(4'hC, 5'd1, 32'hF1, 5'd2, 32'hF2, 5'd6);
      tick();
      inValid = 1'b0;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", outValid, 0);
      check("mid_rst_ready", inReady, 1);
      check("mid_rst_op1", op1, 0);
      tick(); tick();
      reset = 1'b0;
      tick();
      outReady = 1'b1;
      drive(4'hD, 5'd1, 32'h123, 5'd2, 32'h456, 5'd8);
      tick();
      inValid = 1'b0;
      check("post_rst_valid", outValid, 1);
      check("post_rst_op1", op1, 32'h123);
      tick();

      // Random traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         inValid    = 1'($urandom_range(0, 1));
         outReady   = 1'($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 24) == 0);
         inCtrl     = 4'($urandom);
         inRs1      = 5'($urandom_range(0, 3));
         inRs2      = 5'($urandom_range(0, 3));
         inRs1Data  = $urandom;
         inRs2Data  = $urandom;
         inImm      = $urandom;
         inUseImm   = 1'($urandom_range(0, 1));
         inRd       = 5'($urandom);
         set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         tick();
      end
      inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("final_drained", sb.size(), 0);
      check("final_idle", outValid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
